// File: rtl/alien_fleet_ctrl_pkg.sv
// Shared fleet geometry, reset origin and FSM encoding for the alien fleet controller.
// The drawing stage imports the same constants.
package alien_fleet_ctrl_pkg;

    localparam int CELL_W     = 30;
    localparam int CELL_H     = 20;
    localparam int PITCH_X    = 40;
    localparam int PITCH_Y    = 30;
    localparam int GRID_COLS  = 10;
    localparam int GRID_ROWS  = 5;
    localparam int NUM_ALIENS = GRID_COLS * GRID_ROWS;

    // Extent runs from the first cell's left/top edge to the last cell's right/bottom edge.
    localparam int FLEET_W = (GRID_COLS - 1) * PITCH_X + CELL_W;
    localparam int FLEET_H = (GRID_ROWS - 1) * PITCH_Y + CELL_H;

    localparam int ORIGIN_ROW = 40;
    localparam int ORIGIN_COL = 40;

    typedef enum logic [1:0] {
        MOVE_RIGHT = 2'd0,
        MOVE_LEFT  = 2'd1,
        HALT       = 2'd2
    } fleet_state_e;

    function automatic logic [5:0] alienIndex(input logic [2:0] row, input logic [3:0] col);
        return 6'(row) * 6'(GRID_COLS) + 6'(col);
    endfunction

endpackage

// File: rtl/alien_fleet_ctrl_hit_detect.sv
// Combinational bullet probe to alien-cell mapping and alive check.
// Probe sits at the bullet's horizontal centre (col + 5), top row.
module alien_hit_detect
    import alien_fleet_ctrl_pkg::*;
(
    input  logic [8:0]  bulletRow_i,
    input  logic [9:0]  bulletCol_i,
    input  logic        bulletExists_i,
    input  logic [8:0]  fleetRow_i,
    input  logic [9:0]  fleetCol_i,
    input  logic [49:0] grid_i,
    output logic        hit_o,
    output logic [5:0]  hitIndex_o
);

    logic [10:0] probeX, probeY, dx, dy, xOff, yOff;
    logic [3:0]  colIdx;
    logic [2:0]  rowIdx;
    logic        inX, inY, inCell, aliveBit;
    logic [5:0]  index;

    always_comb begin
        probeX   = 11'(bulletCol_i) + 11'd5;
        probeY   = 11'(bulletRow_i);
        dx       = probeX - 11'(fleetCol_i);
        dy       = probeY - 11'(fleetRow_i);
        inX      = (probeX >= 11'(fleetCol_i)) && (dx < 11'(FLEET_W));
        inY      = (probeY >= 11'(fleetRow_i)) && (dy < 11'(FLEET_H));
        colIdx   = 4'(dx / 11'(PITCH_X));
        rowIdx   = 3'(dy / 11'(PITCH_Y));
        xOff     = dx % 11'(PITCH_X);
        yOff     = dy % 11'(PITCH_Y);
        inCell   = (xOff < 11'(CELL_W)) && (yOff < 11'(CELL_H));
        index    = alienIndex(rowIdx, colIdx);
        // Index can exceed the grid when the probe is outside the fleet; guard the select.
        aliveBit = (index < 6'(NUM_ALIENS)) ? grid_i[index] : 1'b0;
        hit_o      = bulletExists_i && inX && inY && inCell && aliveBit;
        hitIndex_o = index;
    end

endmodule

// File: rtl/alien_fleet_ctrl.sv
// Alien fleet motion, descent, hit bookkeeping and game-over flags.
// Optional macro ALIEN_SPEEDUP_EN shortens the step period as aliens die.
module alien_fleet_ctrl
    import alien_fleet_ctrl_pkg::*;
#(
    parameter int STEP_DIV    = 30,
    parameter int H_STEP      = 10,
    parameter int V_STEP      = 10,
    parameter int RIGHT_BOUND = 640,
    parameter int LANDING_ROW = 440
) (
    input  logic        Clk_i,
    input  logic        Reset_i,
    input  logic        FrameTick_i,
    input  logic [8:0]  BulletRow_i,
    input  logic [9:0]  BulletCol_i,
    input  logic        BulletExists_i,
    output logic [49:0] Aliens_Grid_o,
    output logic [8:0]  AliensRow_o,
    output logic [9:0]  AliensCol_o,
    output logic        Hit_o,
    output logic [5:0]  HitIndex_o,
    output logic        Landed_o,
    output logic        AllDead_o
);

    localparam int TICK_W = $clog2(STEP_DIV + 1);

    fleet_state_e      state_q, state_d;
    logic [49:0]       grid_q, grid_d;
    logic [8:0]        row_q, row_d;
    logic [9:0]        col_q, col_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              hit_q, hit_d;
    logic [5:0]        hitIndex_q, hitIndex_d;
    logic              landed_q, landed_d;
    logic              allDead_q, allDead_d;

    logic        detHit;
    logic [5:0]  detIdx;
    logic [31:0] periodM1;
    logic        active, stepNow, hitNow, descend;
    logic [11:0] rightEdge, descRow;

    alien_hit_detect u_hitDetect (
        .bulletRow_i   (BulletRow_i),
        .bulletCol_i   (BulletCol_i),
        .bulletExists_i(BulletExists_i),
        .fleetRow_i    (row_q),
        .fleetCol_i    (col_q),
        .grid_i        (grid_q),
        .hit_o         (detHit),
        .hitIndex_o    (detIdx)
    );

`ifdef ALIEN_SPEEDUP_EN
    logic [31:0] aliveCnt, halfKilled;

    always_comb begin
        aliveCnt = '0;
        for (int i = 0; i < NUM_ALIENS; i++) begin
            aliveCnt = aliveCnt + 32'(grid_q[i]);
        end
        halfKilled = (32'(NUM_ALIENS) - aliveCnt) >> 1;
        // Period floors at 2 frames, so the last value of period-1 is 1.
        if (32'(STEP_DIV) >= halfKilled + 32'd2) begin
            periodM1 = 32'(STEP_DIV) - halfKilled - 32'd1;
        end else begin
            periodM1 = 32'd1;
        end
    end
`else
    assign periodM1 = 32'(STEP_DIV - 1);
`endif

    always_comb begin
        state_d    = state_q;
        grid_d     = grid_q;
        row_d      = row_q;
        col_d      = col_q;
        tick_d     = tick_q;
        hitIndex_d = hitIndex_q;
        landed_d   = landed_q;
        allDead_d  = allDead_q;
        descend    = 1'b0;

        active    = (state_q != HALT);
        stepNow   = active && FrameTick_i && (32'(tick_q) >= periodM1);
        hitNow    = active && detHit;
        hit_d     = hitNow;
        rightEdge = 12'(col_q) + 12'(FLEET_W + H_STEP);
        descRow   = 12'(row_q) + 12'(V_STEP);

        if (active && FrameTick_i) begin
            tick_d = stepNow ? '0 : tick_q + 1'b1;
        end

        // The hit was judged against the pre-step position; both updates land together.
        if (hitNow) begin
            grid_d[detIdx] = 1'b0;
            hitIndex_d     = detIdx;
        end

        if (stepNow) begin
            case (state_q)
                MOVE_RIGHT: begin
                    if (rightEdge <= 12'(RIGHT_BOUND)) begin
                        col_d = col_q + 10'(H_STEP);
                    end else begin
                        descend = 1'b1;
                        state_d = MOVE_LEFT;
                    end
                end
                MOVE_LEFT: begin
                    if (11'(col_q) >= 11'(H_STEP)) begin
                        col_d = col_q - 10'(H_STEP);
                    end else begin
                        descend = 1'b1;
                        state_d = MOVE_RIGHT;
                    end
                end
                default: ;
            endcase
        end

        if (descend) begin
            row_d = 9'(descRow);
            if (descRow + 12'(FLEET_H) >= 12'(LANDING_ROW)) begin
                state_d  = HALT;
                landed_d = 1'b1;
            end
        end

        if (hitNow && (grid_d == '0)) begin
            state_d   = HALT;
            allDead_d = 1'b1;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q    <= MOVE_RIGHT;
            grid_q     <= '1;
            row_q      <= 9'(ORIGIN_ROW);
            col_q      <= 10'(ORIGIN_COL);
            tick_q     <= '0;
            hit_q      <= 1'b0;
            hitIndex_q <= '0;
            landed_q   <= 1'b0;
            allDead_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grid_q     <= grid_d;
            row_q      <= row_d;
            col_q      <= col_d;
            tick_q     <= tick_d;
            hit_q      <= hit_d;
            hitIndex_q <= hitIndex_d;
            landed_q   <= landed_d;
            allDead_q  <= allDead_d;
        end
    end

    assign Aliens_Grid_o = grid_q;
    assign AliensRow_o   = row_q;
    assign AliensCol_o   = col_q;
    assign Hit_o         = hit_q;
    assign HitIndex_o    = hitIndex_q;
    assign Landed_o      = landed_q;
    assign AllDead_o     = allDead_q;

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Self-checking bench for alien_fleet_ctrl: vector table, directed game sequences
// and randomized play against a cell-by-cell reference model of the fleet.
module tb_alien_fleet_ctrl;

    logic        clk;
    logic        reset;
    logic        frameTick;
    logic [8:0]  bulletRow;
    logic [9:0]  bulletCol;
    logic        bulletExists;
    logic [49:0] aliensGrid;
    logic [8:0]  aliensRow;
    logic [9:0]  aliensCol;
    logic        hit;
    logic [5:0]  hitIndex;
    logic        landed;
    logic        allDead;

    int errors;
    int checks;

    localparam logic [63:0] ALL_ONES = 64'h3_FFFF_FFFF_FFFF;

    alien_fleet_ctrl dut (
        .Clk_i         (clk),
        .Reset_i       (reset),
        .FrameTick_i   (frameTick),
        .BulletRow_i   (bulletRow),
        .BulletCol_i   (bulletCol),
        .BulletExists_i(bulletExists),
        .Aliens_Grid_o (aliensGrid),
        .AliensRow_o   (aliensRow),
        .AliensCol_o   (aliensCol),
        .Hit_o         (hit),
        .HitIndex_o    (hitIndex),
        .Landed_o      (landed),
        .AllDead_o     (allDead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: fleet position, direction and alive set, stepped once per clock.
    int       mCol, mRow, mTick, mHitIdx;
    bit       mRight, mHalt, mLanded, mAllDead, mHit;
    bit [49:0] mGrid;

    task automatic modelStep(input bit rst, input bit ft, input bit be, input int br, input int bc);
        int period;
        int found;
        int px;
        bit desc;
        if (rst) begin
            mCol = 40; mRow = 40; mTick = 0; mHitIdx = 0;
            mRight = 1; mHalt = 0; mLanded = 0; mAllDead = 0; mHit = 0;
            mGrid = '1;
            return;
        end
        if (mHalt) begin
            mHit = 0;
            return;
        end
`ifdef ALIEN_SPEEDUP_EN
        period = 30 - (50 - $countones(mGrid)) / 2;
        if (period < 2) period = 2;
`else
        period = 30;
`endif
        found = -1;
        px = bc + 5;
        if (be) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 10; c++) begin
                    if (px >= mCol + 40 * c && px < mCol + 40 * c + 30 &&
                        br >= mRow + 30 * r && br < mRow + 30 * r + 20)
                        found = r * 10 + c;
                end
            end
        end
        mHit = 0;
        if (found >= 0 && mGrid[found]) begin
            mGrid[found] = 1'b0;
            mHit = 1;
            mHitIdx = found;
        end
        if (ft) begin
            mTick++;
            if (mTick >= period) begin
                mTick = 0;
                desc = 0;
                if (mRight) begin
                    if (mCol + 390 + 10 <= 640) mCol += 10;
                    else begin mRow += 10; mRight = 0; desc = 1; end
                end else begin
                    if (mCol >= 10) mCol -= 10;
                    else begin mRow += 10; mRight = 1; desc = 1; end
                end
                if (desc && mRow + 140 >= 440) begin
                    mHalt = 1;
                    mLanded = 1;
                end
            end
        end
        if (mGrid == '0) begin
            mHalt = 1;
            mAllDead = 1;
        end
    endtask

    task automatic checkVal(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit ft, input bit be, input int br, input int bc);
        reset        = rst;
        frameTick    = ft;
        bulletExists = be;
        bulletRow    = 9'(br);
        bulletCol    = 10'(bc);
        @(posedge clk);
        modelStep(rst, ft, be, br, bc);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_grid"},    64'(aliensGrid), 64'(mGrid));
        checkVal({tag, "_row"},     64'(aliensRow),  64'(mRow));
        checkVal({tag, "_col"},     64'(aliensCol),  64'(mCol));
        checkVal({tag, "_hit"},     64'(hit),        64'(mHit));
        checkVal({tag, "_hitidx"},  64'(hitIndex),   64'(mHitIdx));
        checkVal({tag, "_landed"},  64'(landed),     64'(mLanded));
        checkVal({tag, "_alldead"}, 64'(allDead),    64'(mAllDead));
    endtask

    task automatic checkResetValues(input string tag);
        checkVal({tag, "_grid"},    64'(aliensGrid), ALL_ONES);
        checkVal({tag, "_row"},     64'(aliensRow),  64'd40);
        checkVal({tag, "_col"},     64'(aliensCol),  64'd40);
        checkVal({tag, "_hit"},     64'(hit),        64'd0);
        checkVal({tag, "_hitidx"},  64'(hitIndex),   64'd0);
        checkVal({tag, "_landed"},  64'(landed),     64'd0);
        checkVal({tag, "_alldead"}, 64'(allDead),    64'd0);
    endtask

    typedef struct {
        logic       be;
        int         br;
        int         bc;
        logic       expHit;
        logic [5:0] expIdx;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        int idx;
        int tr, tc;
        int br, bc;
        bit ft, be;

        errors = 0;
        checks = 0;
        reset = 1'b0; frameTick = 1'b0; bulletExists = 1'b0;
        bulletRow = '0; bulletCol = '0;

        // Hand-derived hits/misses against the reset fleet at (40,40); HitIndex holds between hits.
        vecs[0]  = '{1'b1,  45,  40, 1'b1, 6'd0};
        vecs[1]  = '{1'b1,  45,  40, 1'b0, 6'd0};
        vecs[2]  = '{1'b1,  45,  70, 1'b0, 6'd0};
        vecs[3]  = '{1'b1,  40,  75, 1'b1, 6'd1};
        vecs[4]  = '{1'b0,  70, 115, 1'b0, 6'd1};
        vecs[5]  = '{1'b1, 160, 395, 1'b1, 6'd49};
        vecs[6]  = '{1'b1, 179, 384, 1'b1, 6'd48};
        vecs[7]  = '{1'b1, 170, 425, 1'b0, 6'd48};
        vecs[8]  = '{1'b1,  39,  40, 1'b0, 6'd48};
        vecs[9]  = '{1'b1,  40,  34, 1'b0, 6'd48};
        vecs[10] = '{1'b1,  60,  35, 1'b0, 6'd48};
        vecs[11] = '{1'b1,  70,  35, 1'b1, 6'd10};

        @(negedge clk);
        applyStimulus(1, 0, 0, 0, 0);
        checkResetValues("reset");

        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 0, vecs[i].be, vecs[i].br, vecs[i].bc);
            checkVal($sformatf("vec%0d_hit", i), 64'(hit), 64'(vecs[i].expHit));
            checkVal($sformatf("vec%0d_idx", i), 64'(hitIndex), 64'(vecs[i].expIdx));
            checkOutput($sformatf("vec%0d", i));
        end
        checkVal("vec_grid0", 64'(aliensGrid[0]), 64'd0);

        // First step lands exactly on the 30th FrameTick.
        applyStimulus(1, 0, 0, 0, 0);
        repeat (29) applyStimulus(0, 1, 0, 0, 0);
        checkVal("step29_col", 64'(aliensCol), 64'd40);
        applyStimulus(0, 1, 0, 0, 0);
        checkVal("step30_col", 64'(aliensCol), 64'd50);
        checkVal("step30_row", 64'(aliensRow), 64'd40);
        checkVal("step30_grid", 64'(aliensGrid), ALL_ONES);
        checkOutput("step30");

        repeat (600) applyStimulus(0, 1, 0, 0, 0);
        checkVal("rightmost_col", 64'(aliensCol), 64'd250);
        checkVal("rightmost_row", 64'(aliensRow), 64'd40);
        repeat (30) applyStimulus(0, 1, 0, 0, 0);
        checkVal("descend_col", 64'(aliensCol), 64'd250);
        checkVal("descend_row", 64'(aliensRow), 64'd50);
        repeat (30) applyStimulus(0, 1, 0, 0, 0);
        checkVal("left_col", 64'(aliensCol), 64'd240);
        checkOutput("left");

        // Randomized play against the model; bullets mostly aimed at a random cell.
        applyStimulus(1, 0, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            ft = ($urandom_range(0, 3) != 0);
            be = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                br = int'($urandom_range(0, 511));
                bc = int'($urandom_range(0, 1023));
            end else begin
                idx = int'($urandom_range(0, 49));
                tr = idx / 10;
                tc = idx % 10;
                bc = mCol + 40 * tc + int'($urandom_range(0, 34)) - 5;
                if (bc < 0) bc = 0;
                br = mRow + 30 * tr + int'($urandom_range(0, 24));
            end
            applyStimulus(0, ft, be, br, bc);
            checkOutput("rand");
        end

        // Shoot every alien in turn, then confirm the fleet is frozen.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(0, 0, 1, 45 + 30 * (i / 10), 50 + 40 * (i % 10));
        end
        checkVal("clear_alldead", 64'(allDead), 64'd1);
        checkVal("clear_grid", 64'(aliensGrid), 64'd0);
        checkVal("clear_lasthit", 64'(hitIndex), 64'd49);
        checkOutput("clear");
        repeat (100) applyStimulus(0, 1, 1, 45, 50);
        checkVal("dead_col", 64'(aliensCol), 64'd40);
        checkVal("dead_hit", 64'(hit), 64'd0);
        checkOutput("dead");

        // March the fleet down to the landing row.
        applyStimulus(1, 0, 0, 0, 0);
        n = 0;
        while (landed !== 1'b1 && n < 30000) begin
            applyStimulus(0, 1, 0, 0, 0);
            n++;
            if (n % 30 == 0) checkOutput("march");
        end
        checkVal("landed_seen", 64'(landed), 64'd1);
        checkVal("landed_row", 64'(aliensRow), 64'd300);
        checkOutput("landed");
        repeat (60) applyStimulus(0, 1, 1, 305, 40);
        checkVal("halt_row", 64'(aliensRow), 64'd300);
        checkVal("halt_hit", 64'(hit), 64'd0);
        checkOutput("halt");
        applyStimulus(1, 0, 0, 0, 0);
        checkResetValues("relaunch");

        // Reset coinciding with a due step and a valid hit wins over both.
        applyStimulus(0, 0, 1, 45, 250);
        checkVal("pre_idx", 64'(hitIndex), 64'd5);
        repeat (29) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 45, 40);
        checkResetValues("midreset");
        applyStimulus(0, 1, 0, 0, 0);
        checkVal("midreset_tick", 64'(aliensCol), 64'd40);
        checkOutput("midreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alien_fleet_ctrl.md
ALIEN_FLEET_CTRL -- requirements
Module: alien_fleet_ctrl

Interface
REQ-001 SHALL provide parameter STEP_DIV, default 30, FrameTicks per fleet step.
REQ-002 SHALL provide parameter H_STEP, default 10, horizontal pixels per step.
REQ-003 SHALL provide parameter V_STEP, default 10, pixels per descent.
REQ-004 SHALL provide parameter RIGHT_BOUND, default 640, exclusive right screen edge.
REQ-005 SHALL provide parameter LANDING_ROW, default 440, fleet-bottom row that ends the game.
REQ-006 Clk  in  1  sole clock; all state updates on rising edge.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 FrameTick  in  1  one-cycle pulse per video frame.
REQ-009 BulletRow  in  9 / BulletCol  in  10 / BulletExists  in  1  player bullet top-left corner and valid flag.
REQ-010 Aliens_Grid  out  50  alive bits, index row*10+col.
REQ-011 AliensRow  out  9 / AliensCol  out  10  fleet top-left pixel.
REQ-012 Hit  out  1  one-cycle pulse when an alien is destroyed; HitIndex  out  6  index of destroyed alien.
REQ-013 Landed  out  1 / AllDead  out  1  sticky game-over flags.

Function
REQ-014 Geometry SHALL be fixed: cell 30x20, pitch 40x30, 10 cols x 5 rows, fleet extent FLEET_W=390, FLEET_H=140.
REQ-015 FSM SHALL have states MOVE_RIGHT, MOVE_LEFT, HALT.
REQ-016 Tick counter SHALL increment on FrameTick; on reaching period-1 it SHALL clear and issue one step in the same cycle.
REQ-017 MOVE_RIGHT step: if AliensCol+FLEET_W+H_STEP <= RIGHT_BOUND, AliensCol += H_STEP; else AliensRow += V_STEP, state -> MOVE_LEFT, column unchanged.
REQ-018 MOVE_LEFT step: if AliensCol >= H_STEP, AliensCol -= H_STEP; else AliensRow += V_STEP, state -> MOVE_RIGHT.
REQ-019 Edge comparisons SHALL be computed at 11 bits minimum; no wrap-around.
REQ-020 After any descent, if new AliensRow+FLEET_H >= LANDING_ROW, state -> HALT and Landed set next cycle.
REQ-021 Hit test: probe point (BulletCol+5, BulletRow); hit when BulletExists, probe >= fleet origin, within fleet extent, cell-local offset x<30 and y<20, and that alive bit is 1.
REQ-022 On hit: alive bit cleared, Hit=1 and HitIndex=index registered one cycle after the sampled inputs; at most one alien per cycle.
REQ-023 Hit and step in the same cycle: hit SHALL be evaluated against pre-step position; both updates applied.
REQ-024 When Aliens_Grid becomes all zero, state -> HALT and AllDead set next cycle.
REQ-025 In HALT: no steps, no hits, Hit=0, outputs frozen until Reset.

Reset
REQ-026 Reset SHALL set Aliens_Grid=all ones, AliensRow=40, AliensCol=40, state MOVE_RIGHT, tick counter 0, Hit=0, HitIndex=0, Landed=0, AllDead=0.
REQ-027 Reset mid-step or mid-hit SHALL override all pending updates in that cycle.

Configuration
REQ-028 Macro ALIEN_SPEEDUP_EN defined: step period = max(2, STEP_DIV - killed/2), killed = 50 - popcount(Aliens_Grid).
REQ-029 Macro undefined: step period constant STEP_DIV; no popcount logic synthesised.

Structure
REQ-030 Shared package SHALL hold cell/pitch/grid constants, FLEET_W, FLEET_H, reset origin and FSM state encoding, also used by the drawing stage.
REQ-031 Sub-module alien_hit_detect SHALL hold the combinational probe-to-index and alive check.

Verification
REQ-032 Reset, 30 FrameTicks -> AliensCol=50, AliensRow=40, Grid all ones.
REQ-033 Steps until AliensCol=250; next step -> AliensRow=50, AliensCol=250, state MOVE_LEFT.
REQ-034 BulletExists=1, BulletCol=40, BulletRow=45 -> Hit pulse, HitIndex=0, Grid[0]=0; repeat same bullet -> no Hit.
REQ-035 Bullet at probe in spacing (BulletCol=70, BulletRow=45) -> no Hit.
REQ-036 Clear all 50 aliens via bullets -> AllDead=1, further FrameTicks do not move fleet.
REQ-037 Run until descent brings AliensRow+140 >= 440 -> Landed=1; Reset asserted -> all REQ-026 values restored next cycle.
